// File: rtl/i2s_clkgen.sv
// i2s_clkgen: audio clock generator running on the PLL global clock.
// Qualifies PLL lock, then produces registered MCLK, BCLK and LRCLK/frame
// sync plus bit/frame strobes and slot/bit indices for the I2S serialiser.
module i2s_clkgen #(
    parameter int MCLK_DIV  = 4,
    parameter int BCLK_DIV  = 8,
    parameter int SLOT_BITS = 32,
    parameter int CHANNELS  = 2,
    parameter int FORMAT    = 0,
    parameter int LOCK_WAIT = 1024,
    localparam int SW = (CHANNELS > 2) ? $clog2(CHANNELS) : 1,
    localparam int BW = $clog2(SLOT_BITS)
) (
    input  logic          refclk,
    input  logic          reset,
    input  logic          pll_lock,
    input  logic          enable,
    output logic          mclk,
    output logic          bclk,
    output logic          lrclk,
    output logic          bit_stb,
    output logic          frame_stb,
    output logic [SW-1:0] slot_idx,
    output logic [BW-1:0] bit_idx,
    output logic          running
);

    localparam int MW = (MCLK_DIV > 2) ? $clog2(MCLK_DIV / 2) : 1;
    localparam int DW = $clog2(BCLK_DIV);
    localparam int CW = $clog2(LOCK_WAIT + 1);

    localparam logic [MW-1:0] M_LAST      = MW'(MCLK_DIV / 2 - 1);
    localparam logic [DW-1:0] B_LAST      = DW'(BCLK_DIV - 1);
    localparam logic [DW-1:0] B_HALF      = DW'(BCLK_DIV / 2);
    localparam logic [BW-1:0] BIT_MSB     = BW'(SLOT_BITS - 1);
    localparam logic [SW-1:0] SLOT_LAST   = SW'(CHANNELS - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(LOCK_WAIT - 1);

    typedef enum logic [2:0] {S_WAIT, S_SETTLE, S_READY, S_RUN, S_DRAIN} state_t;

    state_t          state, next_state;
    logic            lock_m, lock_s;
    logic [CW-1:0]   settle_cnt;
    logic [MW-1:0]   mdiv;
    logic [DW-1:0]   bdiv, bdiv_nx;
    logic [BW-1:0]   bit_nx;
    logic [SW-1:0]   slot_nx;
    logic            frame_end;
    logic            clk_off, mclk_on, run_start, bclk_on, run_next;

    // Sync/word-select value for a bit at (slot s, bit b); cur is the held value
    function automatic logic sync_val(input logic [SW-1:0] s, input logic [BW-1:0] b,
                                      input logic cur);
        if (CHANNELS == 2)
            sync_val = (FORMAT == 0) ? ((b == '0) ? ~s[0] : cur) : s[0];
        else
            sync_val = (FORMAT == 0) ? ((s == SLOT_LAST) && (b == '0))
                                     : ((s == '0) && (b == BIT_MSB));
    endfunction

    // Two-flop synchroniser for the asynchronous PLL lock pin
    always_ff @(posedge refclk or posedge reset) begin
        if (reset) {lock_s, lock_m} <= 2'b00;
        else       {lock_s, lock_m} <= {lock_m, pll_lock};
    end

    // State register and lock settle counter
    always_ff @(posedge refclk or posedge reset) begin
        if (reset) begin
            state      <= S_WAIT;
            settle_cnt <= '0;
        end else begin
            state      <= next_state;
            settle_cnt <= (state == S_SETTLE && next_state == S_SETTLE)
                          ? settle_cnt + CW'(1) : '0;
        end
    end

    // Last bclk cycle of the last bit of the last slot
    assign frame_end = (bdiv == B_LAST) && (bit_idx == '0) && (slot_idx == SLOT_LAST);

    // Next-state logic; losing lock overrides everything
    always_comb begin
        next_state = state;
        if (state != S_WAIT && !lock_s) begin
            next_state = S_WAIT;
        end else begin
            case (state)
                S_WAIT:   if (lock_s) next_state = S_SETTLE;
                S_SETTLE: if (settle_cnt == SETTLE_LAST) next_state = S_READY;
                S_READY:  if (enable) next_state = S_RUN;
                S_RUN:    if (!enable) next_state = S_DRAIN;
                S_DRAIN:  if (frame_end) next_state = enable ? S_RUN : S_READY;
                default:  next_state = S_WAIT;
            endcase
        end
    end

    // Output control decode for the clock datapath
    always_comb begin
        clk_off   = (next_state == S_WAIT) || (next_state == S_SETTLE);
        mclk_on   = (state == S_READY) || (state == S_RUN) || (state == S_DRAIN);
        run_next  = (next_state == S_RUN) || (next_state == S_DRAIN);
        run_start = (state == S_READY) && (next_state == S_RUN);
        bclk_on   = ((state == S_RUN) || (state == S_DRAIN)) && run_next;
    end

    // Next divider and index values for the following strobe
    always_comb begin
        bdiv_nx = (bdiv == B_LAST) ? '0 : bdiv + DW'(1);
        bit_nx  = (bit_idx == '0) ? BIT_MSB : bit_idx - BW'(1);
        slot_nx = slot_idx;
        if (bit_idx == '0)
            slot_nx = (slot_idx == SLOT_LAST) ? '0 : slot_idx + SW'(1);
    end

    // Clock dividers, strobes and indices; everything clears when lock is gone
    always_ff @(posedge refclk or posedge reset) begin
        if (reset || clk_off) begin
            mdiv <= '0; mclk <= 1'b0;
            bdiv <= '0; bclk <= 1'b0; lrclk <= 1'b0;
            bit_stb <= 1'b0; frame_stb <= 1'b0;
            bit_idx <= '0; slot_idx <= '0; running <= 1'b0;
        end else begin
            running <= run_next;
            if (mclk_on) begin
                if (mdiv == M_LAST) begin
                    mdiv <= '0;
                    mclk <= ~mclk;
                end else begin
                    mdiv <= mdiv + MW'(1);
                end
            end else begin
                mdiv <= '0;
                mclk <= 1'b0;
            end

            if (run_start) begin
                bdiv      <= '0;
                bclk      <= 1'b0;
                bit_stb   <= 1'b1;
                frame_stb <= 1'b1;
                bit_idx   <= BIT_MSB;
                slot_idx  <= '0;
                lrclk     <= sync_val('0, BIT_MSB, lrclk);
            end else if (bclk_on) begin
                bdiv      <= bdiv_nx;
                bit_stb   <= (bdiv_nx == '0);
                frame_stb <= (bdiv_nx == '0) && (slot_nx == '0) && (bit_nx == BIT_MSB);
                if (bdiv_nx == B_HALF)   bclk <= 1'b1;
                else if (bdiv_nx == '0)  bclk <= 1'b0;
                if (bdiv_nx == '0) begin
                    bit_idx  <= bit_nx;
                    slot_idx <= slot_nx;
                    lrclk    <= sync_val(slot_nx, bit_nx, lrclk);
                end
            end else begin
                bdiv <= '0; bclk <= 1'b0; lrclk <= 1'b0;
                bit_stb <= 1'b0; frame_stb <= 1'b0;
                bit_idx <= '0; slot_idx <= '0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_clkgen.sv
// Directed bench: a stereo I2S instance and a left-justified TDM instance
// share clock, reset and PLL lock; expected values are hand-derived.
module tb_i2s_clkgen;

    logic refclk, reset, pll_lock, en_st, en_tdm;

    logic       st_mclk, st_bclk, st_lr, st_stb, st_frm, st_run;
    logic [0:0] st_slot;
    logic [1:0] st_bit;
    logic       td_mclk, td_bclk, td_lr, td_stb, td_frm, td_run;
    logic [1:0] td_slot;
    logic [1:0] td_bit;

    int compared, mismatched;
    int u, k;
    bit act;

    i2s_clkgen #(.MCLK_DIV(4), .BCLK_DIV(8), .SLOT_BITS(4), .CHANNELS(2),
                 .FORMAT(0), .LOCK_WAIT(8)) u_st (
        .refclk(refclk), .reset(reset), .pll_lock(pll_lock), .enable(en_st),
        .mclk(st_mclk), .bclk(st_bclk), .lrclk(st_lr), .bit_stb(st_stb),
        .frame_stb(st_frm), .slot_idx(st_slot), .bit_idx(st_bit), .running(st_run));

    i2s_clkgen #(.MCLK_DIV(4), .BCLK_DIV(8), .SLOT_BITS(4), .CHANNELS(4),
                 .FORMAT(1), .LOCK_WAIT(8)) u_td (
        .refclk(refclk), .reset(reset), .pll_lock(pll_lock), .enable(en_tdm),
        .mclk(td_mclk), .bclk(td_bclk), .lrclk(td_lr), .bit_stb(td_stb),
        .frame_stb(td_frm), .slot_idx(td_slot), .bit_idx(td_bit), .running(td_run));

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    initial begin
        compared = 0; mismatched = 0;
        reset = 1'b1; pll_lock = 1'b0; en_st = 1'b0; en_tdm = 1'b0;
        step(2);
        check("rst_st_mclk", st_mclk, 0);
        check("rst_st_bclk", st_bclk, 0);
        check("rst_st_lr",   st_lr, 0);
        check("rst_st_stb",  st_stb, 0);
        check("rst_st_frm",  st_frm, 0);
        check("rst_st_run",  st_run, 0);
        check("rst_td_slot", td_slot, 0);
        check("rst_td_bit",  td_bit, 0);

        // Lock rises; READY lands 11 edges later, mclk rises 2 edges after that
        reset = 1'b0; pll_lock = 1'b1;
        step(12);
        check("lock_mclk_e12", st_mclk, 0);
        step(1);
        check("lock_mclk_e13", st_mclk, 1);
        check("lock_td_mclk",  td_mclk, 1);
        check("ready_run",     st_run, 0);
        check("ready_bclk",    st_bclk, 0);
        step(2);
        check("mclk_e15", st_mclk, 0);
        step(2);
        check("mclk_e17", st_mclk, 1);

        // Run both; stereo drains at slot1 bit2, idles, restarts, drains and
        // is re-enabled before the boundary
        en_st = 1'b1; en_tdm = 1'b1;
        step(1);
        for (int t = 0; t < 302; t++) begin
            act = (t < 128) || (t >= 141);
            u   = (t < 128) ? t : t - 141;
            k   = u / 8;
            check("st_mclk", st_mclk, ((t + 1) % 4) < 2);
            check("st_run",  st_run, act);
            check("st_stb",  st_stb, act && (u % 8 == 0));
            check("st_frm",  st_frm, act && (u % 64 == 0));
            check("st_bclk", st_bclk, act && (u % 8 >= 4));
            check("st_lr",   st_lr, act && (k % 8 >= 3) && (k % 8 <= 6));
            if (act) begin
                check("st_bit",  st_bit, 3 - k % 4);
                check("st_slot", st_slot, (k / 4) % 2);
            end
            check("td_mclk", td_mclk, ((t + 1) % 4) < 2);
            check("td_run",  td_run, 1);
            check("td_stb",  td_stb, t % 8 == 0);
            check("td_frm",  td_frm, t % 128 == 0);
            check("td_bclk", td_bclk, t % 8 >= 4);
            check("td_lr",   td_lr, (t / 8) % 16 == 0);
            check("td_slot", td_slot, (t / 32) % 4);
            check("td_bit",  td_bit, 3 - (t / 8) % 4);
            if (t == 104) en_st = 1'b0;
            if (t == 140) en_st = 1'b1;
            if (t == 181) en_st = 1'b0;
            if (t == 197) en_st = 1'b1;
            step(1);
        end

        // Lock loss mid-frame: outputs clear on the third edge after the pin falls
        pll_lock = 1'b0;
        step(2);
        check("loss_st_run_e2", st_run, 1);
        check("loss_td_run_e2", td_run, 1);
        step(1);
        check("loss_st_run",  st_run, 0);
        check("loss_st_mclk", st_mclk, 0);
        check("loss_st_bclk", st_bclk, 0);
        check("loss_st_lr",   st_lr, 0);
        check("loss_st_stb",  st_stb, 0);
        check("loss_st_bit",  st_bit, 0);
        check("loss_td_run",  td_run, 0);
        check("loss_td_mclk", td_mclk, 0);
        check("loss_td_lr",   td_lr, 0);
        check("loss_td_frm",  td_frm, 0);
        check("loss_td_slot", td_slot, 0);

        // Relock with a one-cycle glitch: settle restarts, READY at G17
        pll_lock = 1'b1;
        step(5);
        pll_lock = 1'b0;
        step(1);
        pll_lock = 1'b1;
        step(7);
        check("glitch_mclk_g13", st_mclk, 0);
        step(5);
        check("glitch_mclk_g18", st_mclk, 0);
        check("glitch_run_g18",  st_run, 1);
        check("glitch_stb_g18",  st_stb, 1);
        check("glitch_frm_g18",  td_frm, 1);
        step(1);
        check("glitch_mclk_g19", st_mclk, 1);
        step(3);

        // Async reset between edges clears outputs without a clock edge
        #3;
        reset = 1'b1;
        #1;
        check("areset_st_run", st_run, 0);
        check("areset_st_bit", st_bit, 0);
        check("areset_td_run", td_run, 0);
        check("areset_td_lr",  td_lr, 0);
        check("areset_td_bit", td_bit, 0);
        step(1);
        reset = 1'b0;
        step(11);
        check("post_rst_run_h11",  st_run, 0);
        check("post_rst_mclk_h11", st_mclk, 0);
        step(1);
        check("post_rst_run_h12",  st_run, 1);
        check("post_rst_mclk_h12", st_mclk, 0);
        step(1);
        check("post_rst_mclk_h13", st_mclk, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
